regfile_mp: RTL and testbench
=============================

# regfile_mp

Parametrised multi-port integer register file with a per-register busy scoreboard for the pipelined RISC-V core. It provides NRD combinational read ports and NWR synchronous write ports, keeps x0 hardwired to zero, and tracks outstanding producers so decode can stall on RAW hazards. It sits between decode/issue, which reads and marks registers busy, and writeback, which writes and clears them.

## Interface
- XLEN, 32, data width in bits
- NREG, 32, register count; power of two, ≥2; AW = $clog2(NREG)
- NRD, 2, read port count, ≥1
- NWR, 2, write port count, ≥1
- clk  in  1  clock
- rst_n  in  1  reset; asynchronous, active-low
- wr_en  in  NWR  per-port write enable
- wr_addr  in  NWR*AW  write addresses, port k at [k*AW +: AW]
- wr_data  in  NWR*XLEN  write data, port k at [k*XLEN +: XLEN]
- rd_addr  in  NRD*AW  read addresses
- rd_data  out  NRD*XLEN  read data
- rd_busy  out  NRD  addressed register has an outstanding producer
- iss_en  in  1  mark iss_addr busy
- iss_addr  in  AW  register being allocated a new producer
- flush  in  1  clear all busy bits (pipeline flush)

## Operation
- Storage: NREG × XLEN registers plus NREG busy bits. Register 0 always reads 0, is never written and is never busy.
- Write: on posedge, each port with wr_en=1 and wr_addr≠0 writes its data. If several ports target the same address, the highest-indexed port wins. A write to a non-busy register is legal.
- Busy clear: a qualifying write clears busy[wr_addr].
- Busy set: iss_en=1 with iss_addr≠0 sets busy[iss_addr]. If the same register is also written that cycle, set wins, because a newer producer now owns it.
- flush=1 clears every busy bit on that edge and overrides both iss_en and write clears. Data writes in the same cycle still occur.
- Read: rd_data/rd_busy are combinational from rd_addr and state. Address 0 gives data 0 and busy 0.
- Reset: all registers 0, all busy bits 0. An async assertion mid-operation discards in-flight writes and issues immediately. rd_data and rd_busy then read 0 for every address.

## Timing
- Write latency: 1 cycle. Data is visible on rd_data after the next posedge; the configuration section covers same-cycle visibility.
- Busy set/clear takes effect at the posedge following the request.
- Read latency: 0 (combinational). No handshake; the caller holds addresses stable.
- Write conflict priority per address: highest-index write port. Busy priority per bit: flush > issue set > write clear.
- Outputs during reset: rd_data=0, rd_busy=0.

## Configuration
- REGFILE_BYPASS_EN defined: a read whose address matches an active same-cycle write (wr_en=1, addr≠0) returns that write's wr_data, taking the highest matching port. rd_busy for that read is 0 unless iss_en targets the same address in that cycle.
- Undefined: reads return stored contents only. A same-cycle write is visible on the following cycle, and rd_busy reflects the stored busy bit.

## Structure
- Shared package regfile_pkg: default XLEN/NREG/NRD/NWR constants, the AW derivation function and the REG_ZERO address constant.
- One sub-module, regfile_wr_sel. It is a combinational priority selector: given an address plus NWR enables, addresses and data, it returns hit and winning data. It is instantiated once per storage register for the write path and once per read port for the bypass.
- Top module holds the storage array, busy vector, read muxing and the bypass generate block.

## Test plan
- Reset then read all addresses → rd_data=0, rd_busy=0 everywhere; write x0=0xDEADBEEF → x0 still reads 0.
- Port0 writes x5=0x11111111 and port1 writes x5=0x22222222 in the same cycle → x5 reads 0x22222222 next cycle.
- iss_en x7, wait 2 cycles → rd_busy=1. Then write x7=0xA5A5A5A5 → next cycle busy=0, data 0xA5A5A5A5.
- Same cycle: iss_en x9 and write x9=0x1234 → next cycle busy=1, data 0x1234. Then flush → busy=0 for all.
- Write x3=0xCAFEF00D while reading x3 in the same cycle → with REGFILE_BYPASS_EN, rd_data=0xCAFEF00D that cycle; without it, the old value that cycle and 0xCAFEF00D next.
- Set x4 busy and write x4=0x55, then assert rst_n low mid-cycle → outputs are 0 immediately, and after release x4 reads 0 with busy=0.

Source files
------------

// File: rtl/regfile_pkg.sv
// Shared definitions for the multi-port register file: default geometry,
// address-width derivation and the hardwired-zero register address.
// Optional feature macro: REGFILE_BYPASS_EN (same-cycle write-to-read bypass).
package regfile_pkg;

    localparam int XLEN_DEF = 32;
    localparam int NREG_DEF = 32;
    localparam int NRD_DEF  = 2;
    localparam int NWR_DEF  = 2;

    // x0 is architecturally zero: never written, never busy
    localparam int REG_ZERO = 0;

    // Address width for a register count; at least one bit so ports stay legal
    function automatic int calc_aw(input int n);
        return (n > 1) ? $clog2(n) : 1;
    endfunction

endpackage

// File: rtl/regfile_wr_sel.sv
// Combinational write-port priority selector. Reports whether any enabled
// write port targets sel_addr (x0 never qualifies) and returns the data of
// the highest-indexed matching port.
module regfile_wr_sel
    import regfile_pkg::*;
#(
    parameter int XLEN = XLEN_DEF,
    parameter int AW   = calc_aw(NREG_DEF),
    parameter int NWR  = NWR_DEF
) (
    input  logic [AW-1:0]       sel_addr,
    input  logic [NWR-1:0]      wr_en,
    input  logic [NWR*AW-1:0]   wr_addr,
    input  logic [NWR*XLEN-1:0] wr_data,
    output logic                hit,
    output logic [XLEN-1:0]     data
);

    // Scan ports in ascending order so the highest-indexed match wins
    always_comb begin
        // NOTE: every output gets a default before the loop; a path that
        // leaves an always_comb output unassigned infers a latch.
        hit  = 1'b0;
        data = '0;
        for (int k = 0; k < NWR; k++) begin
            if (wr_en[k] && (wr_addr[k*AW +: AW] == sel_addr) &&
                (wr_addr[k*AW +: AW] != AW'(REG_ZERO))) begin
                hit  = 1'b1;
                data = wr_data[k*XLEN +: XLEN];
            end
        end
    end

endmodule

// File: rtl/regfile_mp.sv
// Multi-port integer register file with per-register busy scoreboard.
// NRD combinational read ports, NWR synchronous write ports, x0 hardwired
// to zero. Busy bits are set by issue, cleared by writeback, wiped by flush.
// Optional feature macro: REGFILE_BYPASS_EN -- reads see same-cycle writes.
module regfile_mp
    import regfile_pkg::*;
#(
    parameter int  XLEN = XLEN_DEF,
    parameter int  NREG = NREG_DEF,
    parameter int  NRD  = NRD_DEF,
    parameter int  NWR  = NWR_DEF,
    localparam int AW   = calc_aw(NREG)
) (
    input  logic                clk,
    input  logic                rst_n,
    input  logic [NWR-1:0]      wr_en,
    input  logic [NWR*AW-1:0]   wr_addr,
    input  logic [NWR*XLEN-1:0] wr_data,
    input  logic [NRD*AW-1:0]   rd_addr,
    output logic [NRD*XLEN-1:0] rd_data,
    output logic [NRD-1:0]      rd_busy,
    input  logic                iss_en,
    input  logic [AW-1:0]       iss_addr,
    input  logic                flush
);

    logic [XLEN-1:0] mem [NREG];
    logic [NREG-1:0] busy;

    // Per-register write decode: hit and winning data from the write ports
    logic [NREG-1:0] wr_hit;
    logic [XLEN-1:0] wr_val [NREG];

    assign wr_hit[0] = 1'b0;
    assign wr_val[0] = '0;

    for (genvar r = 1; r < NREG; r++) begin : g_wr
        regfile_wr_sel #(
            .XLEN (XLEN),
            .AW   (AW),
            .NWR  (NWR)
        ) u_wr_sel (
            .sel_addr (AW'(r)),
            .wr_en    (wr_en),
            .wr_addr  (wr_addr),
            .wr_data  (wr_data),
            .hit      (wr_hit[r]),
            .data     (wr_val[r])
        );
    end

    // Register storage: x0 is never hit, so it keeps its reset value of zero
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            // NOTE: the array is reset because reads after reset must return
            // zero for every address; a plain RAM macro would not allow this.
            for (int r = 0; r < NREG; r++) begin
                mem[r] <= '0;
            end
        end else begin
            // NOTE: sequential state uses non-blocking assignments so every
            // register samples pre-edge values regardless of statement order.
            for (int r = 0; r < NREG; r++) begin
                if (wr_hit[r]) begin
                    mem[r] <= wr_val[r];
                end
            end
        end
    end

    // Busy scoreboard, priority per bit: flush > issue set > write clear
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            busy <= '0;
        end else if (flush) begin
            busy <= '0;
        end else begin
            for (int r = 1; r < NREG; r++) begin
                if (iss_en && (iss_addr == AW'(r))) begin
                    busy[r] <= 1'b1;
                end else if (wr_hit[r]) begin
                    busy[r] <= 1'b0;
                end
            end
        end
    end

`ifdef REGFILE_BYPASS_EN
    // Bypass decode: one selector per read port against this cycle's writes
    logic [NRD-1:0]  byp_hit;
    logic [XLEN-1:0] byp_val [NRD];

    for (genvar p = 0; p < NRD; p++) begin : g_byp
        regfile_wr_sel #(
            .XLEN (XLEN),
            .AW   (AW),
            .NWR  (NWR)
        ) u_byp_sel (
            .sel_addr (rd_addr[p*AW +: AW]),
            .wr_en    (wr_en),
            .wr_addr  (wr_addr),
            .wr_data  (wr_data),
            .hit      (byp_hit[p]),
            .data     (byp_val[p])
        );
    end
`endif

    // Read muxing; outputs are forced to zero while reset is asserted
    always_comb begin
        rd_data = '0;
        rd_busy = '0;
        for (int p = 0; p < NRD; p++) begin
            rd_data[p*XLEN +: XLEN] = mem[rd_addr[p*AW +: AW]];
            rd_busy[p]              = busy[rd_addr[p*AW +: AW]];
`ifdef REGFILE_BYPASS_EN
            // A forwarded write has retired its producer unless a new one
            // is being issued to the same register this cycle
            if (byp_hit[p]) begin
                rd_data[p*XLEN +: XLEN] = byp_val[p];
                rd_busy[p]              = iss_en && (iss_addr == rd_addr[p*AW +: AW]);
            end
`endif
        end
        if (!rst_n) begin
            rd_data = '0;
            rd_busy = '0;
        end
    end

endmodule

// File: tb/tb_regfile_mp.sv
// Self-checking bench for regfile_mp: directed scenarios plus randomized
// traffic compared against an array-based reference model.
// Honours REGFILE_BYPASS_EN when computing same-cycle read expectations.
module tb_regfile_mp;
    import regfile_pkg::*;

    localparam int XLEN = XLEN_DEF;
    localparam int NREG = NREG_DEF;
    localparam int NRD  = NRD_DEF;
    localparam int NWR  = NWR_DEF;
    localparam int AW   = calc_aw(NREG);

    logic                clk = 1'b0;
    logic                rst_n;
    logic [NWR-1:0]      wr_en;
    logic [NWR*AW-1:0]   wr_addr;
    logic [NWR*XLEN-1:0] wr_data;
    logic [NRD*AW-1:0]   rd_addr;
    logic [NRD*XLEN-1:0] rd_data;
    logic [NRD-1:0]      rd_busy;
    logic                iss_en;
    logic [AW-1:0]       iss_addr;
    logic                flush;

    int n_checks = 0;
    int n_pass   = 0;

    // Reference model state
    logic [XLEN-1:0] m_mem  [NREG];
    bit              m_busy [NREG];

    regfile_mp #(
        .XLEN (XLEN),
        .NREG (NREG),
        .NRD  (NRD),
        .NWR  (NWR)
    ) dut (
        .clk      (clk),
        .rst_n    (rst_n),
        .wr_en    (wr_en),
        .wr_addr  (wr_addr),
        .wr_data  (wr_data),
        .rd_addr  (rd_addr),
        .rd_data  (rd_data),
        .rd_busy  (rd_busy),
        .iss_en   (iss_en),
        .iss_addr (iss_addr),
        .flush    (flush)
    );

    always #5 clk = ~clk;

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1, "watchdog expired");
    end

    task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_checks++;
        if (got === exp) begin
            n_pass++;
        end else begin
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    task automatic model_clear();
        for (int r = 0; r < NREG; r++) begin
            m_mem[r]  = '0;
            m_busy[r] = 1'b0;
        end
    endtask

    // Apply one clock edge of architectural effect to the model
    task automatic model_edge();
        int a;
        if (!rst_n) begin
            model_clear();
        end else begin
            for (int k = 0; k < NWR; k++) begin
                a = int'(wr_addr[k*AW +: AW]);
                if (wr_en[k] && a != 0) begin
                    m_mem[a]  = wr_data[k*XLEN +: XLEN];
                    m_busy[a] = 1'b0;
                end
            end
            if (iss_en && iss_addr != 0) m_busy[int'(iss_addr)] = 1'b1;
            if (flush) begin
                for (int r = 0; r < NREG; r++) m_busy[r] = 1'b0;
            end
        end
    endtask

    task automatic idle();
        wr_en    = '0;
        wr_addr  = '0;
        wr_data  = '0;
        iss_en   = 1'b0;
        iss_addr = '0;
        flush    = 1'b0;
    endtask

    task automatic set_wr(input int k, input int a, input logic [XLEN-1:0] d);
        wr_en[k]               = 1'b1;
        wr_addr[k*AW +: AW]    = AW'(a);
        wr_data[k*XLEN +: XLEN] = d;
    endtask

    task automatic set_rd(input int p, input int a);
        rd_addr[p*AW +: AW] = AW'(a);
    endtask

    task automatic set_iss(input int a);
        iss_en   = 1'b1;
        iss_addr = AW'(a);
    endtask

    // Compare every read port with the model given the current inputs
    task automatic check_reads(input string tag);
        int              a;
        logic [XLEN-1:0] exp_d;
        logic            exp_b;
        for (int p = 0; p < NRD; p++) begin
            a     = int'(rd_addr[p*AW +: AW]);
            exp_d = (a == 0) ? '0 : m_mem[a];
            exp_b = (a == 0) ? 1'b0 : m_busy[a];
`ifdef REGFILE_BYPASS_EN
            for (int k = 0; k < NWR; k++) begin
                if (a != 0 && wr_en[k] && int'(wr_addr[k*AW +: AW]) == a) begin
                    exp_d = wr_data[k*XLEN +: XLEN];
                    exp_b = iss_en && int'(iss_addr) == a;
                end
            end
`endif
            if (!rst_n) begin
                exp_d = '0;
                exp_b = 1'b0;
            end
            check($sformatf("%s data p%0d x%0d", tag, p, a), 64'(rd_data[p*XLEN +: XLEN]), 64'(exp_d));
            check($sformatf("%s busy p%0d x%0d", tag, p, a), 64'(rd_busy[p]), 64'(exp_b));
        end
    endtask

    // Advance one full cycle: posedge (model follows), back to the negedge
    task automatic cycle();
        @(posedge clk);
        model_edge();
        @(negedge clk);
    endtask

    initial begin
        rst_n   = 1'b0;
        rd_addr = '0;
        idle();
        model_clear();
        #1;
        check("in_reset data p0", 64'(rd_data[XLEN-1:0]), 64'(0));
        @(negedge clk);
        @(negedge clk);
        rst_n = 1'b1;

        // Every address reads zero and not busy after reset
        for (int a = 0; a < NREG; a++) begin
            for (int p = 0; p < NRD; p++) set_rd(p, (a + p) % NREG);
            #1 check_reads("reset");
            check("reset explicit x", 64'(rd_data[XLEN-1:0]), 64'(0));
        end
        @(negedge clk);

        // x0 ignores writes
        set_wr(0, 0, 32'hDEADBEEF);
        set_rd(0, 0);
        #1 check_reads("x0 wr");
        cycle();
        idle();
        #1 check("x0 after write", 64'(rd_data[XLEN-1:0]), 64'(0));

        // Same-address write conflict: highest port wins
        set_wr(0, 5, 32'h11111111);
        set_wr(1, 5, 32'h22222222);
        cycle();
        idle();
        set_rd(0, 5);
        #1 check("x5 conflict", 64'(rd_data[XLEN-1:0]), 64'h22222222);
        check_reads("x5");

        // Issue marks busy; writeback clears it
        set_iss(7);
        cycle();
        idle();
        cycle();
        cycle();
        set_rd(0, 7);
        #1 check("x7 busy", 64'(rd_busy[0]), 64'(1));
        set_wr(0, 7, 32'hA5A5A5A5);
        cycle();
        idle();
        #1 check("x7 cleared", 64'(rd_busy[0]), 64'(0));
        check("x7 data", 64'(rd_data[XLEN-1:0]), 64'hA5A5A5A5);

        // Issue beats same-cycle write clear; flush clears everything
        set_iss(9);
        set_wr(1, 9, 32'h1234);
        set_iss(11);
        set_iss(9);
        cycle();
        idle();
        set_rd(0, 9);
        #1 check("x9 busy", 64'(rd_busy[0]), 64'(1));
        check("x9 data", 64'(rd_data[XLEN-1:0]), 64'h1234);
        flush = 1'b1;
        set_iss(12);
        cycle();
        idle();
        for (int a = 0; a < NREG; a++) begin
            for (int p = 0; p < NRD; p++) set_rd(p, a);
            #1 check("flush busy", 64'(rd_busy[0]), 64'(0));
        end
        @(negedge clk);

        // Same-cycle write and read of x3
        set_wr(0, 3, 32'h00000033);
        cycle();
        idle();
        set_wr(1, 3, 32'hCAFEF00D);
        set_rd(0, 3);
        set_rd(1, 3);
`ifdef REGFILE_BYPASS_EN
        #1 check("x3 bypass", 64'(rd_data[XLEN-1:0]), 64'hCAFEF00D);
`else
        #1 check("x3 old", 64'(rd_data[XLEN-1:0]), 64'h00000033);
`endif
        check_reads("x3 same");
        cycle();
        idle();
        #1 check("x3 new", 64'(rd_data[XLEN-1:0]), 64'hCAFEF00D);

        // Asynchronous reset mid-cycle discards the pending write and issue
        set_iss(4);
        cycle();
        idle();
        set_wr(0, 4, 32'h55);
        set_iss(6);
        set_rd(0, 4);
        set_rd(1, 3);
        #1 check_reads("x4 pre-rst");
        #2 rst_n = 1'b0;
        model_clear();
        #1 check("rst x4 data", 64'(rd_data[XLEN-1:0]), 64'(0));
        check("rst x4 busy", 64'(rd_busy[0]), 64'(0));
        check("rst x3 data", 64'(rd_data[2*XLEN-1:XLEN]), 64'(0));
        cycle();
        rst_n = 1'b1;
        idle();
        #1 check("post-rst x4 data", 64'(rd_data[XLEN-1:0]), 64'(0));
        check("post-rst x4 busy", 64'(rd_busy[0]), 64'(0));
        check("post-rst x3 data", 64'(rd_data[2*XLEN-1:XLEN]), 64'(0));
        @(negedge clk);

        // Randomized traffic against the model
        for (int n = 0; n < 600; n++) begin
            idle();
            for (int k = 0; k < NWR; k++) begin
                if ($urandom_range(0, 1) == 1) begin
                    set_wr(k, ($urandom_range(0, 1) == 1) ? $urandom_range(0, 7)
                                                        : $urandom_range(0, NREG - 1),
                           $urandom);
                end
            end
            if ($urandom_range(0, 2) == 0) set_iss($urandom_range(0, 7));
            flush = ($urandom_range(0, 15) == 0);
            for (int p = 0; p < NRD; p++) set_rd(p, $urandom_range(0, 7));
            #1 check_reads("rand");
            cycle();
        end

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
